// File: rtl/gen_sample_fifo.sv
// gen_sample_fifo: first-word-fall-through sample FIFO behind funct_generator.
// It also records samples dropped on overflow, because the generator cannot be stalled.
module gen_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_THRESH = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         flush_i,
  input  logic                         rd_ready_i,
  output logic                         rd_valid_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         afull_o,
  output logic [ADDR_WIDTH:0]          count_o,
  output logic                         ovf_o,
  output logic [7:0]                   drop_cnt_o,
  input  logic                         ovf_clr_i
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AFULL = (ADDR_WIDTH+1)'(AFULL_THRESH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr, w_wptr_nx, w_rptr_nx;
  logic [ADDR_WIDTH:0]   r_count, w_count_nx;
  logic [DATA_WIDTH-1:0] r_data, w_data_nx;
  logic                  r_full, r_empty, r_afull, r_ovf;
  logic [7:0]            r_drop;
  logic                  w_rd, w_wr, w_drop;
  always_comb begin
    w_rd = !r_empty && rd_ready_i && !flush_i;
    w_wr = wr_en_i && !flush_i && (!r_full || w_rd);
    w_drop = wr_en_i && !flush_i && r_full && !w_rd;
    w_wptr_nx = flush_i ? '0 : w_wr ? r_wptr + 1'b1 : r_wptr;
    w_rptr_nx = flush_i ? '0 : w_rd ? r_rptr + 1'b1 : r_rptr;
    w_count_nx = flush_i ? '0 : (w_wr && !w_rd) ? r_count + 1'b1 :
                 (w_rd && !w_wr) ? r_count - 1'b1 : r_count;
    // New head bypasses memory when it is the word being written this cycle
    w_data_nx = (w_count_nx == '0) ? r_data :
                (w_wr && r_wptr == w_rptr_nx) ? data_i : r_mem[w_rptr_nx];
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= data_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= RESET_VALUE;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_wptr  <= w_wptr_nx;
      r_rptr  <= w_rptr_nx;
      r_count <= w_count_nx;
      r_data  <= w_data_nx;
      r_full  <= w_count_nx == C_DEPTH;
      r_empty <= w_count_nx == '0;
      r_afull <= w_count_nx >= C_AFULL;
      r_ovf   <= ovf_clr_i ? w_drop : r_ovf || w_drop;
      r_drop  <= ovf_clr_i ? {7'd0, w_drop} : (w_drop && r_drop != 8'hFF) ? r_drop + 1'b1 : r_drop;
    end
  end
  assign rd_valid_o = !r_empty;
  assign data_o     = r_data;
  assign full_o     = r_full;
  assign empty_o    = r_empty;
  assign afull_o    = r_afull;
  assign count_o    = r_count;
  assign ovf_o      = r_ovf;
  assign drop_cnt_o = r_drop;
endmodule
